// File: rtl/serial_pkg.sv
// Shared types and helpers for the PISO serializer.
// Build option: define SERIAL_PARITY_EN to append an even-parity bit to every frame.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

`ifdef SERIAL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Widest word even_parity() accepts; narrower words are zero-extended,
  // which leaves their parity unchanged.
  localparam int MAX_WIDTH = 64;

  // Serial frame length in bits for a given data word width.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register in front of the shifter. It keeps the
// serial stream gap-free across frames.
module piso_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic             in_ready_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // Occupancy flag: a write wins over a drain, and reset discards the held word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q <= 1'b0;
    end else if (wr_en_i) begin
      full_q <= 1'b1;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  // Word storage. It is only read while full_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q <= wr_data_i;
    end
  end

  assign full_o     = full_q;
  assign data_o     = data_q;
  assign in_ready_o = !full_q && reset;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, with valid/ready input and a
// one-entry holding register for back-to-back frames.
// Build option: SERIAL_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  localparam int CNT_W     = $clog2(WIDTH + 1);
  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
`ifdef SERIAL_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
`ifdef SERIAL_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr, hold_drain;
  logic             accept, consume, last_bit, shifter_free, bypass, load;
  logic [WIDTH-1:0] load_word;

  // A bit leaves when it is presented and downstream advances. The shifter is
  // free when idle or when its final frame bit leaves on this edge.
  assign accept       = in_valid && in_ready;
  assign consume      = sout_valid && shift_en;
  assign last_bit     = (state_q != IDLE) && (cnt_q == LAST_CNT);
  assign shifter_free = (state_q == IDLE) || (consume && last_bit);
  assign bypass       = shifter_free && !hold_full && accept;
  assign hold_drain   = shifter_free && hold_full;
  assign hold_wr      = accept && !bypass;
  assign load         = bypass || hold_drain;
  assign load_word    = hold_full ? hold_data : in_data;

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (hold_wr),
    .wr_data_i (in_data),
    .drain_i   (hold_drain),
    .full_o    (hold_full),
    .data_o    (hold_data),
    .in_ready_o(in_ready)
  );

  // Control state: FSM and bit counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data path: shift register (and parity bit). The FSM gates their use, so they need no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef SERIAL_PARITY_EN
    par_q   <= par_d;
`endif
  end

  // Next state: a load takes priority. Otherwise each consumed bit advances the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef SERIAL_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      state_d = DATA;
      cnt_d   = '0;
      shreg_d = load_word;
`ifdef SERIAL_PARITY_EN
      par_d   = even_parity(MAX_WIDTH'(load_word));
`endif
    end else if (consume) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shreg_d = shreg_q << 1;
      if (last_bit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`ifdef SERIAL_PARITY_EN
      else if (state_q == DATA && cnt_q == LAST_DATA) begin
        state_d = PAR;
      end
`endif
    end
  end

  // Outputs decode from registered state only, so sout/sof/sout_valid are glitch-free.
  always_comb begin
    sout_valid = (state_q != IDLE);
    sof        = (state_q == DATA) && (cnt_q == '0);
    busy       = (state_q != IDLE) || hold_full;
    sout       = 1'b0;
    case (state_q)
      DATA:    sout = shreg_q[WIDTH-1];
`ifdef SERIAL_PARITY_EN
      PAR:     sout = par_q;
`endif
      default: sout = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=4).
// Honours SERIAL_PARITY_EN when the bench is built with it defined.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef SERIAL_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         shift_en = 1'b1;
  logic         in_ready, sout, sout_valid, sof, busy;

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift_en  (shift_en),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sof       (sof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of serial bits still to be presented, each tagged with start-of-frame.
  typedef struct packed {
    logic b;
    logic s;
  } ent_t;
  ent_t mq[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic [31:0] cap = '0;
  logic [31:0] capsof = '0;
  int          cap_n = 0;

  // Number of frames with bits still outstanding (current frame plus any queued ones).
  function automatic int nframes();
    int n = 0;
    foreach (mq[i]) if (mq[i].s) n++;
    if (mq.size() > 0 && !mq[0].s) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) mq.push_back('{b: w[i], s: (i == W - 1)});
`ifdef SERIAL_PARITY_EN
    mq.push_back('{b: ^w, s: 1'b0});
`endif
  endtask

  // Model update at each edge: reset flushes everything. Otherwise consume the head bit, then append an accepted word.
  always @(posedge clk) begin
    bit rdy;
    if (!reset) begin
      mq.delete();
      chk_en = 1'b1;
    end else begin
      rdy = (nframes() < 2);
      if (mq.size() > 0 && shift_en) void'(mq.pop_front());
      if (in_valid && rdy) push_word(in_data);
    end
  end

  // Per-cycle compare of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sout_valid", 32'(sout_valid), 32'(mq.size() > 0));
      chk("sout", 32'(sout), 32'((mq.size() > 0) ? mq[0].b : 1'b0));
      chk("sof", 32'(sof), 32'((mq.size() > 0) ? mq[0].s : 1'b0));
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(reset && (nframes() < 2)));
    end
  end

  // Record consumed bits for the literal frame checks.
  always @(negedge clk) begin
    if (reset && sout_valid && shift_en) begin
      cap    = {cap[30:0], sout};
      capsof = {capsof[30:0], sof};
      cap_n++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_cap();
    cap    = '0;
    capsof = '0;
    cap_n  = 0;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  logic [31:0] e_1011, e_10110110, e_1100, s_one, s_two;

  initial begin
`ifdef SERIAL_PARITY_EN
    e_1011     = 32'b10111;
    e_10110110 = 32'b1011101100;
    e_1100     = 32'b11000;
    s_one      = 32'b10000;
    s_two      = 32'b1000010000;
`else
    e_1011     = 32'b1011;
    e_10110110 = 32'b10110110;
    e_1100     = 32'b1100;
    s_one      = 32'b1000;
    s_two      = 32'b10001000;
`endif

    // Reset held for two cycles: everything idle, not ready.
    reset = 1'b0;
    step(2);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_sout_valid", 32'(sout_valid), 32'd0);
    chk("rst_sof", 32'(sof), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    step(1);

    // Single word.
    clear_cap();
    send(4'b1011);
    step(FLEN + 2);
    chk("single_len", 32'(cap_n), 32'(FLEN));
    chk("single_bits", cap, e_1011);
    chk("single_sof", capsof, s_one);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_valid", 32'(sout_valid), 32'd0);

    // Back-to-back words, gap-free.
    clear_cap();
    send(4'b1011);
    send(4'b0110);
    step(2 * FLEN + 2);
    chk("b2b_len", 32'(cap_n), 32'(2 * FLEN));
    chk("b2b_bits", cap, e_10110110);
    chk("b2b_sof", capsof, s_two);

    // Stall for three cycles while bit 1 (a zero) is presented.
    clear_cap();
    send(4'b1011);
    step(1);
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sout", 32'(sout), 32'd0);
      chk("stall_valid", 32'(sout_valid), 32'd1);
      @(posedge clk);
      #2;
    end
    shift_en = 1'b1;
    step(FLEN + 1);
    chk("stall_bits", cap, e_1011);
    chk("stall_len", 32'(cap_n), 32'(FLEN));

    // Mid-frame reset with a word held, then a fresh frame.
    send(4'b1011);
    send(4'b0110);
    step(1);
    reset = 1'b0;
    step(1);
    chk("abort_valid", 32'(sout_valid), 32'd0);
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_sof", 32'(sof), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    clear_cap();
    send(4'b1100);
    step(FLEN + 2);
    chk("after_abort_bits", cap, e_1100);
    chk("after_abort_sof", capsof, s_one);

    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = W'($urandom);
      shift_en = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 99) != 0);
      step(1);
    end
    in_valid = 1'b0;
    shift_en = 1'b1;
    reset    = 1'b1;
    step(3 * FLEN);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
